conv1_feed_ctrl: RTL and testbench
==================================

CONV1_FEED_CTRL -- requirements
Module: conv1_feed_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: pixel width.
REQ-002 SHALL have parameter IMG_W, default 28: image columns, equal to line-buffer depth.
REQ-003 SHALL have parameter IMG_H, default 28: image rows.
REQ-004 SHALL have parameter NUM_FILTERS, default 6: filter passes per image.
REQ-005 SHALL have parameter ADDR_WIDTH, default $clog2(IMG_W*IMG_H), i.e. 10: image memory address width.
REQ-006 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-007 SHALL have port resetn, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1: single-cycle request to process one image.
REQ-009 SHALL have port stall, input, 1: downstream backpressure, freezes streaming.
REQ-010 SHALL have port mem_rd_en, output, 1: image memory read strobe.
REQ-011 SHALL have port mem_addr, output, ADDR_WIDTH: image memory read address.
REQ-012 SHALL have port mem_rd_data, input, DATA_WIDTH: read data, valid 1 cycle after mem_rd_en.
REQ-013 SHALL have port lb_new_filter, output, 1: line-buffer clear pulse.
REQ-014 SHALL have port lb_data_push, output, 1: line-buffer push.
REQ-015 SHALL have port lb_data_in, output, DATA_WIDTH: pixel to line buffer.
REQ-016 SHALL have port win_col_valid, output, 1: current line-buffer output column forms a full 3-wide window.
REQ-017 SHALL have port filter_idx, output, $clog2(NUM_FILTERS): active filter pass.
REQ-018 SHALL have ports busy, output, 1 (not IDLE) and done, output, 1 (one-cycle completion pulse).

Function
REQ-019 SHALL implement FSM states IDLE, CLEAR, STREAM, DRAIN, DONE.
REQ-020 IDLE: start=1 SHALL go to CLEAR with filter_idx=0; start in any other state SHALL be ignored.
REQ-021 CLEAR: SHALL assert lb_new_filter for exactly one cycle, zero col/row/address counters, then go to STREAM.
REQ-022 STREAM, stall=0: SHALL assert mem_rd_en with mem_addr = row*IMG_W+col, then advance col; col wraps IMG_W-1 -> 0 and increments row.
REQ-023 STREAM, stall=1: mem_rd_en SHALL be 0 and all counters SHALL hold; no address skipped or repeated.
REQ-024 After issuing address IMG_W*IMG_H-1 SHALL go to DRAIN.
REQ-025 lb_data_push SHALL equal mem_rd_en delayed 1 cycle; lb_data_in SHALL be mem_rd_data in that cycle, else 0.
REQ-026 DRAIN SHALL last exactly 2 cycles (memory plus line-buffer output latency); then filter_idx==NUM_FILTERS-1 -> DONE, else filter_idx+1 -> CLEAR.
REQ-027 DONE SHALL assert done for one cycle and return to IDLE; filter_idx SHALL reset to 0.
REQ-028 SHALL track the column of each pushed pixel; win_col_valid SHALL be registered 1 cycle after the push (aligned with line-buffer data_rdy) and high only when that column >= 2.
REQ-029 Unstalled per-filter cost SHALL be 1+IMG_W*IMG_H+2 cycles.

Reset
REQ-030 resetn=0 SHALL asynchronously force IDLE and zero every output, counter and pipeline register, including mid-STREAM.
REQ-031 After reset release, no output SHALL change until start is sampled.

Configuration
REQ-032 Macro CONV1_FEED_ABORT_EN defined: SHALL add input abort, 1 bit; abort=1 in any non-IDLE state SHALL go to IDLE next cycle, drop mem_rd_en and lb_data_push, not assert done, and assert lb_new_filter for one cycle.
REQ-033 Macro undefined: no abort port; behaviour exactly per REQ-019..029.

Verification
REQ-034 Reset with all inputs toggling -> every output 0, busy 0.
REQ-035 IMG 28x28, NUM_FILTERS=2, start, stall=0 -> lb_new_filter 1 cycle after start; mem_addr 0..783 over 784 consecutive cycles; 784 pushes lagging 1 cycle; second clear at start+788; done at start+1575.
REQ-036 stall=1 for 5 cycles after addr 40 issued -> mem_addr stays 41-pending, next read is 41, pushed data sequence gap-free and duplicate-free.
REQ-037 Per row, win_col_valid low for pushed columns 0,1 and high for 2..27: 26 highs per row, 728 per filter pass.
REQ-038 start pulsed mid-STREAM -> ignored, exactly one done per image.
REQ-039 With CONV1_FEED_ABORT_EN, abort at addr 300 -> busy 0 next cycle, no done, one lb_new_filter pulse, next start restarts at addr 0, filter_idx 0.

Source files
------------

// File: rtl/conv1_feed_ctrl.sv
// conv1_feed_ctrl: feed controller for the first convolution layer.
// For every image it makes NUM_FILTERS passes. Each pass clears the line
// buffer, streams every pixel from image memory in raster order, and pushes
// each pixel into the line buffer. It also flags which line-buffer output
// columns form a full 3-wide window.
//
// Optional feature: define CONV1_FEED_ABORT_EN to add the 'abort' input.
// The default build has no abort port.
//
// Ports:
//   clk, resetn    - clock (rising edge) and asynchronous active-low reset
//   start          - one-cycle request to process an image (honoured only when idle)
//   stall          - downstream backpressure; freezes streaming
//   abort          - (CONV1_FEED_ABORT_EN only) return to idle and clear the line buffer
//   mem_rd_en      - image memory read strobe
//   mem_addr       - image memory read address
//   mem_rd_data    - read data, valid one cycle after mem_rd_en
//   lb_new_filter  - line-buffer clear pulse
//   lb_data_push   - line-buffer push strobe
//   lb_data_in     - pixel to the line buffer
//   win_col_valid  - line-buffer output column is the right edge of a 3-wide window
//   filter_idx     - active filter pass
//   busy           - high whenever not idle
//   done           - one-cycle completion pulse
module conv1_feed_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28,
    parameter int NUM_FILTERS = 6,
    parameter int ADDR_WIDTH  = $clog2(IMG_W * IMG_H)
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           start,
    input  logic                           stall,
`ifdef CONV1_FEED_ABORT_EN
    input  logic                           abort,
`endif
    output logic                           mem_rd_en,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic [DATA_WIDTH-1:0]          mem_rd_data,
    output logic                           lb_new_filter,
    output logic                           lb_data_push,
    output logic [DATA_WIDTH-1:0]          lb_data_in,
    output logic                           win_col_valid,
    output logic [$clog2(NUM_FILTERS)-1:0] filter_idx,
    output logic                           busy,
    output logic                           done
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int FI_W  = $clog2(NUM_FILTERS);

    typedef enum logic [2:0] {StIdle, StClear, StStream, StDrain, StDone} state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [FI_W-1:0]     fidx_q, fidx_d;
    logic                drain_q, drain_d;

    // Read/push pipeline: push_col_q is the column of the pixel being pushed.
    logic                push_q;
    logic [COL_W-1:0]    push_col_q;
    logic                win_q;
    logic                abort_clr_q;

    logic                rd_en;
    logic                clear;
    logic                done_w;
    logic                abort_hit;

`ifdef CONV1_FEED_ABORT_EN
    assign abort_hit = abort && (state_q != StIdle);
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        fidx_d  = fidx_q;
        drain_d = drain_q;
        rd_en   = 1'b0;
        clear   = 1'b0;
        done_w  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StClear;
                    fidx_d  = '0;
                end
            end
            StClear: begin
                clear   = 1'b1;
                col_d   = '0;
                row_d   = '0;
                addr_d  = '0;
                drain_d = 1'b0;
                state_d = StStream;
            end
            StStream: begin
                if (!stall) begin
                    rd_en = 1'b1;
                    if (row_q == ROW_W'(IMG_H - 1) && col_q == COL_W'(IMG_W - 1)) begin
                        state_d = StDrain;
                        drain_d = 1'b0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        if (col_q == COL_W'(IMG_W - 1)) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            StDrain: begin
                // Two cycles: memory read latency plus line-buffer output latency.
                drain_d = 1'b1;
                if (drain_q) begin
                    drain_d = 1'b0;
                    if (fidx_q == FI_W'(NUM_FILTERS - 1)) begin
                        state_d = StDone;
                        fidx_d  = '0;
                    end else begin
                        state_d = StClear;
                        fidx_d  = fidx_q + 1'b1;
                    end
                end
            end
            StDone: begin
                done_w  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (abort_hit) begin
            state_d = StIdle;
            fidx_d  = '0;
            drain_d = 1'b0;
            rd_en   = 1'b0;
            clear   = 1'b0;
            done_w  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            col_q       <= '0;
            row_q       <= '0;
            addr_q      <= '0;
            fidx_q      <= '0;
            drain_q     <= 1'b0;
            push_q      <= 1'b0;
            push_col_q  <= '0;
            win_q       <= 1'b0;
            abort_clr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            addr_q      <= addr_d;
            fidx_q      <= fidx_d;
            drain_q     <= drain_d;
            push_q      <= rd_en;
            if (rd_en) begin
                push_col_q <= col_q;
            end
            win_q       <= abort_hit ? 1'b0 : (push_q && push_col_q >= COL_W'(2));
            abort_clr_q <= abort_hit;
        end
    end

    assign mem_rd_en     = rd_en;
    assign mem_addr      = addr_q;
    assign lb_new_filter = clear || abort_clr_q;
    assign lb_data_push  = push_q;
    assign lb_data_in    = push_q ? mem_rd_data : '0;
    assign win_col_valid = win_q;
    assign filter_idx    = fidx_q;
    assign busy          = (state_q != StIdle);
    assign done          = done_w;

endmodule

// File: tb/tb_conv1_feed_ctrl.sv
// Self-checking bench for conv1_feed_ctrl (28x28 image, 2 filter passes).
// A timeline model (pass number and slot within the pass) predicts every output
// each cycle; literal checks pin the unstalled timing and the per-job counts.
module tb_conv1_feed_ctrl;

    localparam int DW   = 8;
    localparam int W    = 28;
    localparam int H    = 28;
    localparam int NF   = 2;
    localparam int AW   = 10;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic          abort = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          lb_new_filter;
    logic          lb_data_push;
    logic [DW-1:0] lb_data_in;
    logic          win_col_valid;
    logic [0:0]    filter_idx;
    logic          busy;
    logic          done;

    conv1_feed_ctrl #(
        .DATA_WIDTH (DW),
        .IMG_W      (W),
        .IMG_H      (H),
        .NUM_FILTERS(NF),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .stall        (stall),
`ifdef CONV1_FEED_ABORT_EN
        .abort        (abort),
`endif
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .lb_new_filter(lb_new_filter),
        .lb_data_push (lb_data_push),
        .lb_data_in   (lb_data_in),
        .win_col_valid(win_col_valid),
        .filter_idx   (filter_idx),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input int a);
        return 8'((a * 13 + 7) & 255);
    endfunction

    // Image memory: one-cycle read latency, junk when not reading.
    always @(posedge clk) begin
        mem_rd_data <= mem_rd_en ? pix(int'(mem_addr)) : 8'($urandom);
    end

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Timeline model
    bit m_active, m_done, m_abclr;
    int m_pass, m_slot;
    bit m_prev_rd, m_prev_push;
    int m_prev_addr, m_prev_push_addr;

    // Event counters over the current job
    int ev_clear[$];
    int ev_done[$];
    int ev_push, ev_win;

    task automatic model_reset();
        m_active = 0; m_done = 0; m_abclr = 0; m_pass = 0; m_slot = 0;
        m_prev_rd = 0; m_prev_push = 0; m_prev_addr = 0; m_prev_push_addr = 0;
    endtask

    task automatic clear_events();
        ev_clear.delete(); ev_done.delete(); ev_push = 0; ev_win = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, int'(mem_rd_en), 0);
        chk({tag, "_addr"}, int'(mem_addr), 0);
        chk({tag, "_newf"}, int'(lb_new_filter), 0);
        chk({tag, "_push"}, int'(lb_data_push), 0);
        chk({tag, "_din"}, int'(lb_data_in), 0);
        chk({tag, "_win"}, int'(win_col_valid), 0);
        chk({tag, "_fidx"}, int'(filter_idx), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    // One clock cycle: drive inputs after the falling edge, compare, advance model.
    task automatic step(input bit st, input bit sl, input bit ab_req);
        bit ab, in_stream, ab_hit, e_rd, e_clr, e_done, e_busy, e_win, nd;
        int e_din;
`ifdef CONV1_FEED_ABORT_EN
        ab = ab_req;
`else
        ab = 1'b0;
`endif
        @(negedge clk);
        cyc++;
        start = st; stall = sl; abort = ab;
        #1;
        in_stream = m_active && m_slot >= 1 && m_slot <= NPIX;
        ab_hit = ab && (m_active || m_done);
        e_rd   = in_stream && !sl && !ab_hit;
        e_clr  = (m_active && m_slot == 0 && !ab_hit) || m_abclr;
        e_done = m_done && !ab_hit;
        e_busy = m_active || m_done;
        e_din  = m_prev_rd ? int'(pix(m_prev_addr)) : 0;
        e_win  = m_prev_push && ((m_prev_push_addr % W) >= 2);
        chk("mem_rd_en", int'(mem_rd_en), int'(e_rd));
        chk("lb_new_filter", int'(lb_new_filter), int'(e_clr));
        chk("done", int'(done), int'(e_done));
        chk("busy", int'(busy), int'(e_busy));
        chk("lb_data_push", int'(lb_data_push), int'(m_prev_rd));
        chk("lb_data_in", int'(lb_data_in), e_din);
        chk("win_col_valid", int'(win_col_valid), int'(e_win));
        if (in_stream) chk("mem_addr", int'(mem_addr), m_slot - 1);
        if (m_active) chk("filter_idx", int'(filter_idx), m_pass);
        if (lb_new_filter) ev_clear.push_back(cyc);
        if (done) ev_done.push_back(cyc);
        if (lb_data_push) ev_push++;
        if (win_col_valid) ev_win++;
        // advance model to next cycle
        m_prev_push = ab_hit ? 1'b0 : m_prev_rd;
        m_prev_push_addr = m_prev_addr;
        m_prev_rd = e_rd;
        m_prev_addr = m_slot - 1;
        m_abclr = ab_hit;
        nd = 0;
        if (ab_hit) begin
            m_active = 0;
        end else if (m_active) begin
            if (!(in_stream && sl)) begin
                if (m_slot == NPIX + 2) begin
                    if (m_pass == NF - 1) begin
                        m_active = 0; nd = 1;
                    end else begin
                        m_pass++; m_slot = 0;
                    end
                end else begin
                    m_slot++;
                end
            end
        end else if (!m_done && st) begin
            m_active = 1; m_pass = 0; m_slot = 0;
        end
        m_done = nd;
    endtask

    // Run one image from a start pulse; rnd adds random stall/start noise and
    // a forced 5-cycle stall after address 40 is issued.
    task automatic run_job(input bit rnd, output int start_cyc);
        int guard, stall_left;
        bit sl, st;
        step(1'b1, 1'b0, 1'b0);
        start_cyc = cyc;
        guard = 0;
        stall_left = 0;
        while ((m_active || m_done) && guard < 6000) begin
            guard++;
            if (rnd && m_prev_rd && m_prev_addr == 40) stall_left = 5;
            if (stall_left > 0) begin
                sl = 1'b1; stall_left--;
            end else begin
                sl = rnd && ($urandom_range(0, 3) == 0);
            end
            st = rnd && ($urandom_range(0, 49) == 0);
            step(st, sl, 1'b0);
        end
        chk("job_completes_in_budget", int'(m_active || m_done), 0);
    endtask

    initial begin
        int sc;
        model_reset();
        // Reset held with inputs toggling: all outputs must stay zero.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'(i); stall = 1'(i >> 1); abort = 1'(i);
            #1;
            chk_all_zero("reset");
        end
        @(negedge clk);
        start = 0; stall = 0; abort = 0;
        resetn = 1'b1;
        // Idle after release: nothing moves without start (stall toggling).
        for (int i = 0; i < 5; i++) step(1'b0, 1'(i), 1'b0);

        // Unstalled job: pin timing and counts with literal values.
        clear_events();
        run_job(1'b0, sc);
        chk("clear_count", ev_clear.size(), 2);
        if (ev_clear.size() == 2) begin
            chk("first_clear_ofs", ev_clear[0] - sc, 1);
            chk("second_clear_ofs", ev_clear[1] - sc, 788);
        end
        chk("done_count", ev_done.size(), 1);
        if (ev_done.size() == 1) chk("done_ofs", ev_done[0] - sc, 1575);
        chk("push_count", ev_push, 2 * 784);
        chk("win_count", ev_win, 2 * 728);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

        // Randomly stalled jobs with stray start pulses.
        for (int j = 0; j < 2; j++) begin
            clear_events();
            run_job(1'b1, sc);
            chk("rnd_done_count", ev_done.size(), 1);
            chk("rnd_push_count", ev_push, 2 * 784);
            chk("rnd_win_count", ev_win, 2 * 728);
            step(1'b0, 1'b0, 1'b0);
        end

        // Asynchronous reset mid-stream.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        chk_all_zero("midreset");
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        clear_events();
        run_job(1'b0, sc);
        chk("post_reset_done_count", ev_done.size(), 1);

`ifdef CONV1_FEED_ABORT_EN
        begin
            int guard;
            step(1'b0, 1'b0, 1'b1);  // abort while idle is ignored
            clear_events();
            step(1'b1, 1'b0, 1'b0);
            guard = 0;
            while (!(m_prev_rd && m_prev_addr == 300) && guard < 2000) begin
                guard++;
                step(1'b0, 1'b0, 1'b0);
            end
            chk("abort_reach_300", int'(m_prev_rd && m_prev_addr == 300), 1);
            clear_events();
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0);
            chk("abort_busy_low", int'(busy), 0);
            step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
            chk("abort_clear_pulses", ev_clear.size(), 1);
            chk("abort_no_done", ev_done.size(), 0);
            clear_events();
            run_job(1'b0, sc);
            chk("abort_restart_done", ev_done.size(), 1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
